// File: rtl/kvazaar_lambda_loader.sv
// Avalon-MM shadow bank for lambda/RDO words, streamed to the Kvazaar core over valid/ready.
// Build option: define LAMBDA_LOADER_PULSE_EN to turn lambda_loaded into a 1-cycle pulse.
module kvazaar_lambda_loader #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [31:0]      lam_data,
  output logic [IDX_W-1:0] lam_idx,
  output logic             lam_valid,
  input  logic             lam_ready,
  output logic             lambda_loaded
);

  localparam int PTR_W = $clog2(NUM_WORDS + 1);
  localparam logic [PTR_W-1:0] FULL = PTR_W'(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic             ovf, err, loaded;
  logic [31:0]      bank [NUM_WORDS];

  logic wr_en, data_wr, ctrl_wr, stat_wr, go, abort, busy, bank_we;

  assign wr_en   = chipselect & ~write_n;
  assign data_wr = wr_en && (address == 2'd0);
  assign ctrl_wr = wr_en && (address == 2'd1);
  assign stat_wr = wr_en && (address == 2'd2);
  assign abort   = ctrl_wr & writedata[1];
  assign go      = ctrl_wr & writedata[0] & ~writedata[1];
  assign busy    = (state != IDLE);
  assign bank_we = data_wr && !busy && (wr_ptr != FULL);

  // Bank has no reset; its contents only matter once wr_ptr reaches FULL.
  always_ff @(posedge clk) begin
    if (bank_we)
      bank[wr_ptr[IDX_W-1:0]] <= writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      ovf           <= 1'b0;
      err           <= 1'b0;
      loaded        <= 1'b0;
      readdata      <= '0;
      lam_data      <= '0;
      lam_idx       <= '0;
      lam_valid     <= 1'b0;
      lambda_loaded <= 1'b0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(wr_ptr);
        2'd2:    readdata <= {28'b0, err, ovf, loaded, busy};
        default: readdata <= '0;
      endcase

      // Clear first so that a set event later in this block takes priority.
      if (stat_wr) begin
        if (writedata[2]) ovf <= 1'b0;
        if (writedata[3]) err <= 1'b0;
      end

`ifdef LAMBDA_LOADER_PULSE_EN
      lambda_loaded <= 1'b0;
`endif

      if (abort) begin
        state     <= IDLE;
        lam_valid <= 1'b0;
        wr_ptr    <= '0;
        loaded    <= 1'b0;
`ifndef LAMBDA_LOADER_PULSE_EN
        lambda_loaded <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (data_wr) begin
              if (wr_ptr == FULL) ovf <= 1'b1;
              else                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (go) begin
              if (wr_ptr == FULL) begin
                state     <= SEND;
                lam_valid <= 1'b1;
                lam_idx   <= '0;
                lam_data  <= bank[0];
                loaded    <= 1'b0;
`ifndef LAMBDA_LOADER_PULSE_EN
                lambda_loaded <= 1'b0;
`endif
              end else begin
                err <= 1'b1;
              end
            end
          end
          SEND: begin
            if (data_wr || go) err <= 1'b1;
            // Outputs only move on a handshake, so they hold while stalled.
            if (lam_valid && lam_ready) begin
              if (lam_idx == LAST) begin
                state     <= DONE;
                lam_valid <= 1'b0;
              end else begin
                lam_idx  <= lam_idx + IDX_W'(1);
                lam_data <= bank[lam_idx + IDX_W'(1)];
              end
            end
          end
          DONE: begin
            if (data_wr || go) err <= 1'b1;
            lambda_loaded <= 1'b1;
            loaded        <= 1'b1;
            wr_ptr        <= '0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kvazaar_lambda_loader.sv
// Directed + randomized bench for kvazaar_lambda_loader against a queue-based model of the register map.
module tb_kvazaar_lambda_loader;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address = 2'd3;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] lam_data;
  logic [1:0]  lam_idx;
  logic        lam_valid;
  logic        lam_ready = 1'b0;
  logic        lambda_loaded;

  int total = 0;
  int bad   = 0;

  // Reference model: words accepted into the bank, plus sticky flags.
  logic [31:0] m_words[$];
  logic        m_ovf = 1'b0, m_err = 1'b0, m_loaded = 1'b0;

  kvazaar_lambda_loader #(.NUM_WORDS(N), .IDX_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .lam_data(lam_data), .lam_idx(lam_idx), .lam_valid(lam_valid),
    .lam_ready(lam_ready), .lambda_loaded(lambda_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
    address = 2'd3;
  endtask

  task automatic data_wr(input logic [31:0] w);
    if (m_words.size() < N) m_words.push_back(w);
    else                    m_ovf = 1'b1;
    wr(2'd0, w);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    rd(2'd0, v);
    chk({tag, "_data_rd"}, v, 32'(m_words.size()));
    rd(2'd2, v);
    chk({tag, "_status"}, v, {28'b0, m_err, m_ovf, m_loaded, 1'b0});
  endtask

  // mode 0: ready always high, 1: toggling, 2: random. abort_after<0 disables abort.
  task automatic run_set(input string tag, input int mode, input int abort_after);
    logic [31:0] exp_q[$];
    int acc = 0;
    int ncyc = 0;
    logic r;
    exp_q = m_words;
    lam_ready = (mode == 0);
    wr(2'd1, 32'h1);
    m_loaded = 1'b0;
    chk({tag, "_ll_low_after_go"}, lambda_loaded, 1'b0);
    for (int c = 0; c < 200 && acc < N; c++) begin
      chk({tag, "_valid"}, lam_valid, 1'b1);
      chk({tag, "_idx"}, lam_idx, 32'(acc));
      chk({tag, "_data"}, lam_data, exp_q[acc]);
      if (acc == abort_after) begin
        lam_ready = 1'b1;
        wr(2'd1, 32'h2);
        lam_ready = 1'b0;
        m_words.delete();
        m_loaded = 1'b0;
        chk({tag, "_abort_valid"}, lam_valid, 1'b0);
        chk({tag, "_abort_ll"}, lambda_loaded, 1'b0);
        $display("%s: aborted after %0d accepts", tag, acc);
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      lam_ready = r;
      @(negedge clk);
      ncyc++;
      if (r) acc++;
    end
    lam_ready = 1'b0;
    chk({tag, "_accepts"}, 32'(acc), 32'(N));
    if (mode == 0) chk({tag, "_consecutive"}, 32'(ncyc), 32'(N));
    chk({tag, "_valid_drop"}, lam_valid, 1'b0);
    chk({tag, "_ll_not_yet"}, lambda_loaded, 1'b0);
    @(negedge clk);
    chk({tag, "_ll_rise"}, lambda_loaded, 1'b1);
    @(negedge clk);
`ifdef LAMBDA_LOADER_PULSE_EN
    chk({tag, "_ll_pulse_end"}, lambda_loaded, 1'b0);
`else
    chk({tag, "_ll_hold"}, lambda_loaded, 1'b1);
`endif
    m_words.delete();
    m_loaded = 1'b1;
    $display("%s: set of %0d words delivered in %0d cycles", tag, acc, ncyc);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) data_wr($urandom);
  endtask

  initial begin
    logic [31:0] v;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", lam_valid, 1'b0);
    chk("rst_data", lam_data, 32'h0);
    chk("rst_idx", lam_idx, 32'h0);
    chk("rst_ll", lambda_loaded, 1'b0);
    chk("rst_readdata", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_regs("rst");

    // T1: fixed words, ready held high
    data_wr(32'h10); data_wr(32'h20); data_wr(32'h30); data_wr(32'h40);
    check_regs("t1_loaded");
    run_set("t1", 0, -1);
    check_regs("t1_done");

    // T2: ready toggling
    load_random(N);
    run_set("t2", 1, -1);
    check_regs("t2_done");

    // T3: short set, GO rejected
    load_random(3);
    wr(2'd1, 32'h1);
    m_err = 1'b1;
    chk("t3_valid0", lam_valid, 1'b0);
    @(negedge clk);
    chk("t3_valid1", lam_valid, 1'b0);
    check_regs("t3_err");
    wr(2'd2, 32'h8);
    m_err = 1'b0;
    check_regs("t3_clr");
    wr(2'd1, 32'h3);  // both bits: ABORT wins, empties the short set
    m_words.delete();
    m_loaded = 1'b0;
    chk("t3_abort_valid", lam_valid, 1'b0);
    check_regs("t3_abort");

    // T4: overflow, only first four words are sent
    load_random(5);
    check_regs("t4_ovf");
    run_set("t4", 2, -1);
    wr(2'd2, 32'h4);
    m_ovf = 1'b0;
    check_regs("t4_clr");

    // T5: abort after 2 accepts, then full reload
    load_random(N);
    run_set("t5_abort", 2, 2);
    check_regs("t5_after_abort");
    load_random(N);
    run_set("t5_reload", 2, -1);
    check_regs("t5_done");

    // Randomized sets
    for (int k = 0; k < 3; k++) begin
      load_random(N);
      run_set("rand", 2, -1);
    end
    check_regs("rand_done");

    // T6: asynchronous reset mid-SEND
    load_random(N);
    lam_ready = 1'b0;
    wr(2'd1, 32'h1);
    chk("t6_sending", lam_valid, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", lam_valid, 1'b0);
    chk("t6_data", lam_data, 32'h0);
    chk("t6_idx", lam_idx, 32'h0);
    chk("t6_ll", lambda_loaded, 1'b0);
    chk("t6_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_words.delete();
    m_ovf = 1'b0; m_err = 1'b0; m_loaded = 1'b0;
    @(negedge clk);
    check_regs("t6_post");
    data_wr(32'h10); data_wr(32'h20); data_wr(32'h30); data_wr(32'h40);
    run_set("t6_rerun", 0, -1);
    check_regs("t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
